lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles to wait for mem_ack_w_i before aborting (8-bit counter).
REQ-002 clk_w_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_w_i  input  1  reset, synchronous, active-high.
REQ-004 req_valid_w_i  input  1  execute stage presents a load/store.
REQ-005 req_ready_w_o  output  1  LSU can accept; high only in IDLE.
REQ-006 alu_res_w_i  input  32  effective address from ALU (base + offset).
REQ-007 store_data_w_i  input  32  rs2 value for stores.
REQ-008 funct3_w_i  input  3  RV32 width/sign field (LB/LH/LW/LBU/LHU; SB/SH/SW).
REQ-009 is_store_w_i  input  1  1 = store, 0 = load.
REQ-010 mem_req_w_o  output  1  memory request, held until ack or timeout.
REQ-011 mem_we_w_o  output  1  write enable, valid with mem_req_w_o.
REQ-012 mem_addr_w_o  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-013 mem_wdata_w_o  output  32  lane-replicated store data.
REQ-014 mem_be_w_o  output  4  byte enables.
REQ-015 mem_ack_w_i  input  1  memory completes the access this cycle.
REQ-016 mem_rdata_w_i  input  32  read word, valid when mem_ack_w_i high on a load.
REQ-017 rsp_valid_w_o  output  1  one-cycle completion pulse.
REQ-018 rsp_data_w_o  output  32  extended load result; 0 for stores and errors.
REQ-019 err_w_o  output  1  valid with rsp_valid_w_o: misaligned, illegal funct3, or timeout.

Function
REQ-020 FSM states IDLE, REQ, RESP; IDLE->REQ on accept (req_valid & req_ready) of legal aligned op; IDLE->RESP on accept of illegal/misaligned op; REQ->RESP on ack or timeout; RESP->IDLE unconditionally.
REQ-021 Address, funct3, is_store and store data captured into registers on accept; inputs ignored otherwise.
REQ-022 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0; no memory access, rsp at accept+1 with err=1.
REQ-023 Illegal funct3: loads 3'b011/110/111, stores >=3'b011; handled as REQ-022.
REQ-024 mem_req_w_o/we/addr/wdata/be registered; asserted first cycle after accept, stable while in REQ.
REQ-025 Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}; SH be=4'b0011<<addr[1:0], wdata={2{d[15:0]}}; SW be=4'b1111, wdata=d.
REQ-026 Loads: be=4'b1111; byte/half selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-027 Ack in first REQ cycle legal; rsp_valid_w_o asserted the cycle after ack, data registered from mem_rdata_w_i at ack.
REQ-028 Ack while not in REQ ignored; no state change.
REQ-029 Timeout counter clears on entering REQ, increments each REQ cycle without ack; on reaching TIMEOUT_CYCLES mem_req drops, RESP with err=1, data 0.
REQ-030 Ack in the same cycle timeout is reached: ack wins, err=0.
REQ-031 Throughput: one op per 3 cycles minimum (accept, REQ, RESP).

Reset
REQ-032 Reset: state IDLE, req_ready_w_o=1, mem_req_w_o=0, mem_we_w_o=0, mem_addr/wdata/be=0, rsp_valid_w_o=0, rsp_data_w_o=0, err_w_o=0, counter=0.
REQ-033 Reset mid-operation abandons the access; mem_req_w_o low after the reset edge; no rsp pulse produced.

Structure
REQ-034 Package lsu_pkg holds funct3 constants (LB..SW), FSM state encoding, default TIMEOUT_CYCLES.
REQ-035 Combinational sub-module lsu_align performs store lane steering/byte enables and load extraction/extension.

Verification
REQ-036 SW addr 0x100, data 0xDEADBEEF, ack after 2 cycles -> mem_addr 0x100, be 4'hF, wdata 0xDEADBEEF, we=1; rsp_valid 1 cycle, err 0.
REQ-037 LB addr 0x203, rdata 0x80FF0011 -> be 4'hF, addr 0x200, rsp_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SH addr 0x302, data 0x0000ABCD -> be 4'b1100, wdata 0xABCDABCD; LH addr 0x301 -> no mem_req, rsp next cycle err=1.
REQ-039 LW, ack never asserted, TIMEOUT_CYCLES=4 -> mem_req high 4 cycles, then rsp err=1 data 0, ready next cycle.
REQ-040 Reset asserted during REQ -> mem_req low after edge, no rsp_valid, req_ready=1; stray ack in IDLE ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state encoding and op-legality helper for the LSU
package lsu_pkg;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Stores only have SB/SH/SW; loads additionally have the unsigned byte/half forms.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return (f3 > F3_SW);
    end
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - execute-stage request, memory bus and response signals of the LSU
interface lsu_if;

  logic        req_valid_w_i;
  logic        req_ready_w_o;
  logic [31:0] alu_res_w_i;
  logic [31:0] store_data_w_i;
  logic [2:0]  funct3_w_i;
  logic        is_store_w_i;

  logic        mem_req_w_o;
  logic        mem_we_w_o;
  logic [31:0] mem_addr_w_o;
  logic [31:0] mem_wdata_w_o;
  logic [3:0]  mem_be_w_o;
  logic        mem_ack_w_i;
  logic [31:0] mem_rdata_w_i;

  logic        rsp_valid_w_o;
  logic [31:0] rsp_data_w_o;
  logic        err_w_o;

  modport slave (
    input  req_valid_w_i, alu_res_w_i, store_data_w_i, funct3_w_i, is_store_w_i,
    input  mem_ack_w_i, mem_rdata_w_i,
    output req_ready_w_o, mem_req_w_o, mem_we_w_o, mem_addr_w_o, mem_wdata_w_o, mem_be_w_o,
    output rsp_valid_w_o, rsp_data_w_o, err_w_o
  );

  modport master (
    output req_valid_w_i, alu_res_w_i, store_data_w_i, funct3_w_i, is_store_w_i,
    output mem_ack_w_i, mem_rdata_w_i,
    input  req_ready_w_o, mem_req_w_o, mem_we_w_o, mem_addr_w_o, mem_wdata_w_o, mem_be_w_o,
    input  rsp_valid_w_o, rsp_data_w_o, err_w_o
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane steering / byte enables and load byte-half extraction
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] rshift;

  always_comb begin
    be         = 4'b1111;
    wdata      = store_data;
    load_data  = '0;
    misaligned = 1'b0;
    illegal    = f3_illegal(is_store, funct3);
    // Selected byte/half lands in the low bits; half offsets are only 0 or 2 once aligned.
    rshift     = rdata >> {addr_lo, 3'b000};

    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase

    if (is_store) begin
      case (funct3)
        F3_SB: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        F3_SH: begin
          be    = 4'b0011 << addr_lo;
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = store_data;
        end
      endcase
    end else begin
      case (funct3)
        F3_LB:   load_data = {{24{rshift[7]}}, rshift[7:0]};
        F3_LH:   load_data = {{16{rshift[15]}}, rshift[15:0]};
        F3_LBU:  load_data = {24'd0, rshift[7:0]};
        F3_LHU:  load_data = {16'd0, rshift[15:0]};
        F3_LW:   load_data = rdata;
        default: load_data = '0;
      endcase
    end
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: accepts one op, drives a single memory access, returns a response
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic   clk_w_i,
  input logic   rst_w_i,
  lsu_if.slave  bus
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e state, next_state;

  logic [31:0] addr_q;
  logic [31:0] store_data_q;
  logic [2:0]  funct3_q;
  logic        is_store_q;
  logic [7:0]  cnt_q;

  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        err_q;

  logic        accept;
  logic        bad_op;
  logic        ack_done;
  logic        timeout_hit;

  // In IDLE the aligner looks at the live request; afterwards at the captured op.
  logic [31:0] addr_sel;
  logic [31:0] store_data_sel;
  logic [2:0]  funct3_sel;
  logic        is_store_sel;

  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load_data;
  logic        al_misaligned;
  logic        al_illegal;

  assign addr_sel       = (state == ST_IDLE) ? bus.alu_res_w_i    : addr_q;
  assign store_data_sel = (state == ST_IDLE) ? bus.store_data_w_i : store_data_q;
  assign funct3_sel     = (state == ST_IDLE) ? bus.funct3_w_i     : funct3_q;
  assign is_store_sel   = (state == ST_IDLE) ? bus.is_store_w_i   : is_store_q;

  lsu_align u_align (
    .addr_lo    (addr_sel[1:0]),
    .funct3     (funct3_sel),
    .is_store   (is_store_sel),
    .store_data (store_data_sel),
    .rdata      (bus.mem_rdata_w_i),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load_data),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  always_ff @(posedge clk_w_i) begin
    if (rst_w_i) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    bad_op      = al_misaligned | al_illegal;
    ack_done    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = bus.req_valid_w_i;
        if (accept) begin
          next_state = bad_op ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack has priority over a timeout landing in the same cycle.
        ack_done    = bus.mem_ack_w_i;
        timeout_hit = !bus.mem_ack_w_i && (cnt_q == TO_LAST);
        if (ack_done || timeout_hit) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_w_i) begin
    if (rst_w_i) begin
      addr_q       <= '0;
      store_data_q <= '0;
      funct3_q     <= '0;
      is_store_q   <= 1'b0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;

      if (accept) begin
        addr_q       <= bus.alu_res_w_i;
        store_data_q <= bus.store_data_w_i;
        funct3_q     <= bus.funct3_w_i;
        is_store_q   <= bus.is_store_w_i;
        cnt_q        <= '0;
        if (bad_op) begin
          rsp_valid_q <= 1'b1;
          err_q       <= 1'b1;
        end else begin
          mem_req_q   <= 1'b1;
          mem_we_q    <= bus.is_store_w_i;
          mem_addr_q  <= {bus.alu_res_w_i[31:2], 2'b00};
          mem_wdata_q <= al_wdata;
          mem_be_q    <= al_be;
        end
      end

      if (ack_done) begin
        mem_req_q   <= 1'b0;
        mem_we_q    <= 1'b0;
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= is_store_q ? 32'd0 : al_load_data;
      end else if (timeout_hit) begin
        mem_req_q   <= 1'b0;
        mem_we_q    <= 1'b0;
        rsp_valid_q <= 1'b1;
        err_q       <= 1'b1;
      end else if (state == ST_REQ) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign bus.req_ready_w_o = (state == ST_IDLE);
  assign bus.mem_req_w_o   = mem_req_q;
  assign bus.mem_we_w_o    = mem_we_q;
  assign bus.mem_addr_w_o  = mem_addr_q;
  assign bus.mem_wdata_w_o = mem_wdata_q;
  assign bus.mem_be_w_o    = mem_be_q;
  assign bus.rsp_valid_w_o = rsp_valid_q;
  assign bus.rsp_data_w_o  = rsp_data_q;
  assign bus.err_w_o       = err_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - scoreboard bench for the LSU with directed load/store vectors
module tb_lsu;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_exp_t;

  logic clk;
  logic rst;
  lsu_if bus();

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_w_i (clk),
    .rst_w_i (rst),
    .bus     (bus)
  );

  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int cur_len = 0;
  int last_len = 0;
  logic req_prev = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT starts a memory access or returns a response.
  initial begin
    mem_exp_t m;
    rsp_exp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur_len = 0;
        req_prev = 1'b0;
      end else begin
        if (bus.rsp_valid_w_o) begin
          if (rsp_q.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
          end else begin
            r = rsp_q.pop_front();
            chk("rsp_data", bus.rsp_data_w_o, r.data);
            chk("rsp_err", {31'd0, bus.err_w_o}, {31'd0, r.err});
          end
        end
        if (bus.mem_req_w_o && !req_prev) begin
          if (mem_q.size() == 0) begin
            chk("memreq_unexpected", 32'd1, 32'd0);
          end else begin
            m = mem_q.pop_front();
            chk("mem_we", {31'd0, bus.mem_we_w_o}, {31'd0, m.we});
            chk("mem_addr", bus.mem_addr_w_o, m.addr);
            chk("mem_be", {28'd0, bus.mem_be_w_o}, {28'd0, m.be});
            if (m.we) chk("mem_wdata", bus.mem_wdata_w_o, m.wdata);
          end
        end
        if (bus.mem_req_w_o) begin
          cur_len++;
        end else if (req_prev) begin
          last_len = cur_len;
          cur_len = 0;
        end
        req_prev = bus.mem_req_w_o;
      end
    end
  end

  task automatic do_op(input string nm, input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] f3, input logic st, input int ack_dly,
                       input logic [31:0] rdata, input logic exp_mem, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                       input logic exp_err, input int exp_len);
    mem_exp_t m;
    rsp_exp_t r;
    int n;
    if (exp_mem) begin
      m.we = st;
      m.addr = {addr[31:2], 2'b00};
      m.wdata = exp_wdata;
      m.be = exp_be;
      mem_q.push_back(m);
    end
    r.data = exp_data;
    r.err = exp_err;
    rsp_q.push_back(r);

    bus.alu_res_w_i = addr;
    bus.store_data_w_i = data;
    bus.funct3_w_i = f3;
    bus.is_store_w_i = st;
    bus.req_valid_w_i = 1'b1;
    @(posedge clk);
    #1 bus.req_valid_w_i = 1'b0;
    bus.alu_res_w_i = 32'h5A5A5A5A;
    bus.store_data_w_i = 32'hA5A5A5A5;

    if (!exp_mem) begin
      chk({nm, "_early_rsp"}, {31'd0, bus.rsp_valid_w_o}, 32'd1);
      chk({nm, "_no_memreq"}, {31'd0, bus.mem_req_w_o}, 32'd0);
    end else if (ack_dly >= 0) begin
      repeat (ack_dly) begin
        @(posedge clk);
        #1;
      end
      bus.mem_ack_w_i = 1'b1;
      bus.mem_rdata_w_i = rdata;
      @(posedge clk);
      #1 bus.mem_ack_w_i = 1'b0;
      bus.mem_rdata_w_i = 32'h0;
    end

    n = 0;
    while (!bus.req_ready_w_o && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_ready"}, {31'd0, bus.req_ready_w_o}, 32'd1);
    if (exp_len > 0) chk({nm, "_req_len"}, last_len, exp_len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mem_exp_t m;
    rst = 1'b1;
    bus.req_valid_w_i = 1'b0;
    bus.alu_res_w_i = '0;
    bus.store_data_w_i = '0;
    bus.funct3_w_i = '0;
    bus.is_store_w_i = 1'b0;
    bus.mem_ack_w_i = 1'b0;
    bus.mem_rdata_w_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.req_ready_w_o}, 32'd1);
    chk("rst_memreq", {31'd0, bus.mem_req_w_o}, 32'd0);
    chk("rst_we", {31'd0, bus.mem_we_w_o}, 32'd0);
    chk("rst_addr", bus.mem_addr_w_o, 32'd0);
    chk("rst_wdata", bus.mem_wdata_w_o, 32'd0);
    chk("rst_be", {28'd0, bus.mem_be_w_o}, 32'd0);
    chk("rst_rsp", {bus.rsp_data_w_o[29:0], bus.rsp_valid_w_o, bus.err_w_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    //    name      addr          data          f3      st  ack rdata         mem  be       wdata         rsp_data      err len
    do_op("sw",     32'h100, 32'hDEADBEEF, 3'b010, 1, 2, 32'h0,        1, 4'hF,    32'hDEADBEEF, 32'h0,        0, 3);
    do_op("lb",     32'h203, 32'h0,        3'b000, 0, 0, 32'h80FF0011, 1, 4'hF,    32'h0,        32'hFFFFFF80, 0, 1);
    do_op("lbu",    32'h203, 32'h0,        3'b100, 0, 1, 32'h80FF0011, 1, 4'hF,    32'h0,        32'h00000080, 0, 2);
    do_op("sh",     32'h302, 32'h0000ABCD, 3'b001, 1, 1, 32'h0,        1, 4'b1100, 32'hABCDABCD, 32'h0,        0, 2);
    do_op("lh_mis", 32'h301, 32'h0,        3'b001, 0, 0, 32'h0,        0, 4'h0,    32'h0,        32'h0,        1, 0);
    do_op("lw_to",  32'h400, 32'h0,        3'b010, 0, -1, 32'h0,       1, 4'hF,    32'h0,        32'h0,        1, 4);
    do_op("lh",     32'h402, 32'h0,        3'b001, 0, 0, 32'h80017F00, 1, 4'hF,    32'h0,        32'hFFFF8001, 0, 1);
    do_op("lhu",    32'h400, 32'h0,        3'b101, 0, 0, 32'h80017F00, 1, 4'hF,    32'h0,        32'h00007F00, 0, 1);
    do_op("sb",     32'h501, 32'h12345678, 3'b000, 1, 0, 32'h0,        1, 4'b0010, 32'h78787878, 32'h0,        0, 1);
    do_op("ld_ill", 32'h0,   32'h0,        3'b011, 0, 0, 32'h0,        0, 4'h0,    32'h0,        32'h0,        1, 0);
    do_op("st_ill", 32'h0,   32'h0,        3'b100, 1, 0, 32'h0,        0, 4'h0,    32'h0,        32'h0,        1, 0);
    do_op("lw_race",32'h600, 32'h0,        3'b010, 0, 3, 32'hCAFEF00D, 1, 4'hF,    32'h0,        32'hCAFEF00D, 0, 4);
    do_op("sw_mis", 32'h102, 32'h11111111, 3'b010, 1, 0, 32'h0,        0, 4'h0,    32'h0,        32'h0,        1, 0);

    // Reset in the middle of an access: no response may follow.
    m.we = 1'b0;
    m.addr = 32'h700;
    m.wdata = 32'h0;
    m.be = 4'hF;
    mem_q.push_back(m);
    bus.alu_res_w_i = 32'h700;
    bus.funct3_w_i = 3'b010;
    bus.is_store_w_i = 1'b0;
    bus.req_valid_w_i = 1'b1;
    @(posedge clk);
    #1 bus.req_valid_w_i = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_memreq", {31'd0, bus.mem_req_w_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_memreq", {31'd0, bus.mem_req_w_o}, 32'd0);
    chk("rstmid_rsp", {31'd0, bus.rsp_valid_w_o}, 32'd0);
    chk("rstmid_ready", {31'd0, bus.req_ready_w_o}, 32'd1);
    rst = 1'b0;

    // Stray ack while idle must be ignored.
    bus.mem_ack_w_i = 1'b1;
    bus.mem_rdata_w_i = 32'hFFFFFFFF;
    @(posedge clk);
    #1 bus.mem_ack_w_i = 1'b0;
    repeat (2) begin
      chk("stray_ready", {31'd0, bus.req_ready_w_o}, 32'd1);
      chk("stray_memreq", {31'd0, bus.mem_req_w_o}, 32'd0);
      chk("stray_rsp", {31'd0, bus.rsp_valid_w_o}, 32'd0);
      @(posedge clk);
      #1;
    end

    do_op("lw_post", 32'h10, 32'h0, 3'b010, 0, 0, 32'h11223344, 1, 4'hF, 32'h0, 32'h11223344, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rsp_q_drained", rsp_q.size(), 32'd0);
    chk("mem_q_drained", mem_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
